// File: rtl/resp_join_cut.sv
// Joins per-cluster accelerator responses into a single CVA6 response stream
// and merges per-cluster load/store completion pulses into single pulses.
module resp_join_cut #(
    parameter int NrClusters   = 2,
    parameter int DataWidth    = 64,
    parameter int TransIdWidth = 3,
    parameter int FifoDepth    = 2,
    parameter int MaxPending   = 7
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrClusters-1:0]              cl_resp_valid_i,
    output logic [NrClusters-1:0]              cl_resp_ready_o,
    input  logic [NrClusters*DataWidth-1:0]    cl_result_i,
    input  logic [NrClusters*TransIdWidth-1:0] cl_trans_id_i,
    input  logic [NrClusters-1:0]              cl_exc_valid_i,
    input  logic [NrClusters*DataWidth-1:0]    cl_exc_tval_i,
    input  logic [NrClusters-1:0]              cl_store_complete_i,
    input  logic [NrClusters-1:0]              cl_load_complete_i,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic [DataWidth-1:0]               resp_result_o,
    output logic [TransIdWidth-1:0]            resp_trans_id_o,
    output logic                               resp_exc_valid_o,
    output logic [DataWidth-1:0]               resp_exc_tval_o,
    output logic                               store_complete_o,
    output logic                               load_complete_o,
    output logic                               error_o
);

    localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW  = $clog2(FifoDepth + 1);
    localparam int PendW = $clog2(MaxPending + 1);
    localparam logic [PtrW-1:0]  LastPtr = PtrW'(FifoDepth - 1);
    localparam logic [CntW-1:0]  FullCnt = CntW'(FifoDepth);
    localparam logic [PendW-1:0] MaxCnt  = PendW'(MaxPending);

    logic [DataWidth-1:0]    r_result  [NrClusters][FifoDepth];
    logic [TransIdWidth-1:0] r_trans_id[NrClusters][FifoDepth];
    logic                    r_exc     [NrClusters][FifoDepth];
    logic [DataWidth-1:0]    r_tval    [NrClusters][FifoDepth];

    logic [NrClusters-1:0][PtrW-1:0] r_wptr;
    logic [NrClusters-1:0][PtrW-1:0] r_rptr;
    logic [NrClusters-1:0][CntW-1:0] r_count;

    logic [1:0][NrClusters-1:0][PendW-1:0] r_pend;
    logic [1:0]                            r_complete;
    logic                                  r_error;

    logic [NrClusters-1:0]   w_full;
    logic [NrClusters-1:0]   w_nonempty;
    logic [NrClusters-1:0]   w_push;
    logic                    w_resp_valid;
    logic                    w_pop;

    logic [DataWidth-1:0]    w_head_result[NrClusters];
    logic [TransIdWidth-1:0] w_head_id    [NrClusters];
    logic                    w_head_exc   [NrClusters];
    logic [DataWidth-1:0]    w_head_tval  [NrClusters];

    logic                    w_any_exc;
    logic [DataWidth-1:0]    w_sel_tval;
    logic                    w_id_mismatch;

    logic [1:0][NrClusters-1:0]            w_pulse;
    logic [1:0]                            w_join;
    logic [1:0][NrClusters-1:0]            w_sat;
    logic [1:0][NrClusters-1:0][PendW-1:0] w_pend_next;

    always_comb begin
        for (int i = 0; i < NrClusters; i++) begin
            w_full[i]     = (r_count[i] == FullCnt);
            w_nonempty[i] = (r_count[i] != '0);
            w_push[i]     = cl_resp_valid_i[i] && !w_full[i];
        end
    end

    assign w_resp_valid    = &w_nonempty;
    assign w_pop           = w_resp_valid && resp_ready_i;
    assign cl_resp_ready_o = ~w_full;

    // Payload storage is not reset; outputs are gated by valid instead.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrClusters; i++) begin
            if (w_push[i]) begin
                r_result[i][r_wptr[i]]   <= cl_result_i[i*DataWidth +: DataWidth];
                r_trans_id[i][r_wptr[i]] <= cl_trans_id_i[i*TransIdWidth +: TransIdWidth];
                r_exc[i][r_wptr[i]]      <= cl_exc_valid_i[i];
                r_tval[i][r_wptr[i]]     <= cl_exc_tval_i[i*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < NrClusters; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= (r_wptr[i] == LastPtr) ? '0 : r_wptr[i] + 1'b1;
                end
                if (w_pop) begin
                    r_rptr[i] <= (r_rptr[i] == LastPtr) ? '0 : r_rptr[i] + 1'b1;
                end
                if (w_push[i] && !w_pop) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end else if (!w_push[i] && w_pop) begin
                    r_count[i] <= r_count[i] - 1'b1;
                end
            end
        end
    end

    // The lowest-index excepting cluster supplies tval.
    always_comb begin
        w_any_exc     = 1'b0;
        w_sel_tval    = '0;
        w_id_mismatch = 1'b0;
        for (int i = 0; i < NrClusters; i++) begin
            w_head_result[i] = r_result[i][r_rptr[i]];
            w_head_id[i]     = r_trans_id[i][r_rptr[i]];
            w_head_exc[i]    = r_exc[i][r_rptr[i]];
            w_head_tval[i]   = r_tval[i][r_rptr[i]];
        end
        for (int i = 0; i < NrClusters; i++) begin
            if (w_head_exc[i] && !w_any_exc) begin
                w_sel_tval = w_head_tval[i];
            end
            w_any_exc = w_any_exc | w_head_exc[i];
            if (w_head_id[i] != w_head_id[0]) begin
                w_id_mismatch = 1'b1;
            end
        end
    end

    assign resp_valid_o     = w_resp_valid;
    assign resp_result_o    = w_resp_valid ? w_head_result[0] : '0;
    assign resp_trans_id_o  = w_resp_valid ? w_head_id[0] : '0;
    assign resp_exc_valid_o = w_resp_valid && w_any_exc;
    assign resp_exc_tval_o  = w_resp_valid ? w_sel_tval : '0;

    // Index 0 tracks stores, index 1 loads; a pulse arriving this cycle counts toward the join.
    always_comb begin
        w_pulse[0] = cl_store_complete_i;
        w_pulse[1] = cl_load_complete_i;
        for (int k = 0; k < 2; k++) begin
            w_join[k] = 1'b1;
            for (int i = 0; i < NrClusters; i++) begin
                if (r_pend[k][i] == '0 && !w_pulse[k][i]) begin
                    w_join[k] = 1'b0;
                end
            end
            for (int i = 0; i < NrClusters; i++) begin
                w_sat[k][i]       = 1'b0;
                w_pend_next[k][i] = r_pend[k][i];
                if (w_join[k]) begin
                    w_pend_next[k][i] = r_pend[k][i] + PendW'(w_pulse[k][i]) - PendW'(1);
                end else if (w_pulse[k][i]) begin
                    if (r_pend[k][i] == MaxCnt) begin
                        w_sat[k][i] = 1'b1;
                    end else begin
                        w_pend_next[k][i] = r_pend[k][i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend     <= '0;
            r_complete <= '0;
            r_error    <= 1'b0;
        end else begin
            r_pend     <= w_pend_next;
            r_complete <= w_join;
            if ((w_resp_valid && w_id_mismatch) || (|w_sat)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign store_complete_o = r_complete[0];
    assign load_complete_o  = r_complete[1];
    assign error_o          = r_error;

endmodule

// File: doc/resp_join_cut.md
Name: resp_join_cut

Overview:
- Downstream counterpart of the request fork: collects the accelerator responses returned by the Ara clusters and merges them into one response stream towards CVA6.
- Buffers each cluster's responses in a small per-cluster FIFO. Emits a merged response only when every cluster has produced its response for the same instruction.
- Also joins the per-cluster load/store completion pulses into single completion pulses towards CVA6.

Parameters:
- NrClusters, 2, number of clusters joined (>=2).
- DataWidth, 64, width of scalar result and exception tval.
- TransIdWidth, 3, width of transaction id.
- FifoDepth, 2, entries per cluster response FIFO (>=1).
- MaxPending, 7, maximum outstanding completion pulses counted per cluster.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cl_resp_valid_i  in  NrClusters  per-cluster response valid
- cl_resp_ready_o  out  NrClusters  per-cluster response ready
- cl_result_i  in  NrClusters x DataWidth  per-cluster scalar result
- cl_trans_id_i  in  NrClusters x TransIdWidth  per-cluster transaction id
- cl_exc_valid_i  in  NrClusters  per-cluster exception flag
- cl_exc_tval_i  in  NrClusters x DataWidth  per-cluster exception tval
- cl_store_complete_i  in  NrClusters  per-cluster store-complete pulse
- cl_load_complete_i  in  NrClusters  per-cluster load-complete pulse
- resp_valid_o  out  1  merged response valid
- resp_ready_i  in  1  CVA6 ready
- resp_result_o  out  DataWidth  merged result
- resp_trans_id_o  out  TransIdWidth  merged transaction id
- resp_exc_valid_o  out  1  merged exception flag
- resp_exc_tval_o  out  DataWidth  merged exception tval
- store_complete_o  out  1  joined store-complete pulse
- load_complete_o  out  1  joined load-complete pulse
- error_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_ni=0):
  - All FIFOs empty and all counters zero.
  - Every output is 0 except cl_resp_ready_o, which is all ones.
- Per-cluster FIFO:
  - Stores {result, trans_id, exc_valid, exc_tval}.
  - cl_resp_ready_o[i] = !full[i]. It does not depend on cl_resp_valid_i.
  - Push when cl_resp_valid_i[i] && cl_resp_ready_o[i].
  - No fall-through: data pushed in cycle t is visible at the head from cycle t+1.
  - Push and pop in the same cycle on a full FIFO are not allowed, because ready is already low.
  - Push and pop in the same cycle on a non-full FIFO keeps the count unchanged.
- Join and merge:
  - resp_valid_o = AND of all FIFO non-empty flags. Minimum latency is 1 cycle after the last cluster handshake.
  - On resp_valid_o && resp_ready_i, all FIFOs pop their head in the same cycle.
  - Outputs are stable while resp_valid_o && !resp_ready_i.
  - resp_result_o = head result of cluster 0.
  - resp_trans_id_o = head trans_id of cluster 0.
  - resp_exc_valid_o = OR of the head exc_valid flags.
  - resp_exc_tval_o = tval of the lowest-index cluster whose head exc_valid=1; 0 when none.
  - While resp_valid_o=1, if any head trans_id differs from cluster 0's, error_o is set. The response is still emitted.
- Completion join (separate for store and for load):
  - Each cluster has a counter of width clog2(MaxPending+1).
  - join = all counters > 0. The output pulse is registered: store_complete_o/load_complete_o is 1 in the cycle after join, for exactly one cycle per join.
  - In the join cycle, every counter decrements by 1. A pulse arriving for cluster i in the same cycle also increments it, so counter i is unchanged.
  - Counters are capped at MaxPending. A pulse arriving at MaxPending without a same-cycle decrement is dropped and sets error_o.
- error_o is sticky until reset.
- Reset asserted mid-operation discards all buffered responses and counts immediately. Outputs return to their reset values asynchronously.

Test Plan:
- Aligned responses: cluster 0 and cluster 1 send {result=0x11, id=2, no exc} together in cycle 0, with resp_ready_i=1 -> resp_valid_o=1 in cycle 1 only, result=0x11, id=2, exc=0.
- Skewed arrival plus backpressure:
  - Setup: cluster 0 responds at cycle 0, cluster 1 at cycle 5; resp_ready_i=0 until cycle 8.
  - Required: resp_valid_o rises at cycle 6 and stays stable until the handshake at cycle 8.
  - Required: cluster 0 FIFO keeps its entry until then; with FifoDepth=2, a third cluster 0 response finds cl_resp_ready_o[0]=0.
- Exception merge: cluster 1 exc_valid=1 with tval=0xDEAD, cluster 0 exc_valid=0 -> resp_exc_valid_o=1, resp_exc_tval_o=0xDEAD.
- Id mismatch: cluster 0 sends id=1, cluster 1 sends id=3 -> response emitted with id=1, and error_o=1 from then until reset.
- Completion join:
  - Stimulus: cluster 0 sends store pulses at cycles 0 and 1; cluster 1 sends one at cycle 4 and one at cycle 4+k.
  - Required: store_complete_o pulses at cycle 5 and at cycle 5+k; counters return to 0.
  - Saturation: 8 pulses on cluster 0 alone sets error_o.
- Reset mid-operation: with 1 entry in each FIFO and counters at 2, assert rst_ni=0 -> resp_valid_o=0 immediately and all counters 0. After reset is released, no stale response or completion pulse appears.
